// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one async FIFO write port
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wfull,
    output logic                    winc,
    output logic [DSIZE-1:0]        wdata,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d, last_q, last_d, pick;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_g, last_g, xfer, done;
    logic [DSIZE-1:0] data_g;

    // nearest valid requester after the previous winner, wrapping NREQ-1 -> 0
    always_comb begin
        pick = last_q;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[GW'((int'(last_q) + k) % NREQ)]) pick = GW'((int'(last_q) + k) % NREQ);
        end
    end

    // route the granted requester's lines to the shared port
    always_comb begin
        valid_g = 1'b0;
        last_g  = 1'b0;
        data_g  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == GW'(i)) begin
                valid_g = req_valid[i];
                last_g  = req_last[i];
                data_g  = req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    assign busy     = state_q == S_BURST;
    assign xfer     = busy & valid_g & ~wfull;
    assign done     = busy & (~valid_g | (xfer & (last_g | cnt_q == CW'(BURST - 1))));
    assign winc     = xfer;
    assign wdata    = busy ? data_g : '0;
    assign grant_id = grant_q;

    // one-hot ready, only for the granted requester and only on a real write
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) req_ready[i] = xfer & (grant_q == GW'(i));
    end

    // next state: grant on IDLE->BURST, count words, release on last/terminal/abandon
    always_comb begin
        state_d = busy ? (done ? S_IDLE : S_BURST) : (|req_valid ? S_BURST : S_IDLE);
        grant_d = (!busy && |req_valid) ? pick : grant_q;
        last_d  = done ? grant_q : last_q;
        cnt_d   = (busy && !done) ? (xfer ? cnt_q + CW'(1) : cnt_q) : '0;
    end

    // state registers with synchronous reset
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenario bench for the FIFO write arbiter
module tb_fifo_wr_arbiter;
    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic [31:0] req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    logic        wfull = 1'b0;
    logic [3:0]  req_ready;
    logic        winc;
    logic [7:0]  wdata;
    logic [1:0]  grant_id;
    logic        busy;
    logic [7:0]  exp_data [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    int          tests = 0;
    int          fails = 0;

    fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .BURST(4)) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .winc(winc),
        .wdata(wdata), .grant_id(grant_id), .busy(busy)
    );

    always #5 wclk = ~wclk;

    task automatic cyc();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        req_valid = '0;
        req_last = '0;
        wfull = 1'b0;
        cyc();
        wrst = 1'b0;
    endtask

    task automatic test_reset();
        wrst = 1'b1;
        req_valid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            cyc();
            tests++;
            if ({winc, req_ready, busy} !== 6'b0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got winc/ready/busy=%b want 000000", c, {winc, req_ready, busy});
            end
        end
        wrst = 1'b0;
        #1;
        tests++;
        if ({busy, winc, grant_id} !== 4'b0) begin
            fails++;
            $display("FAIL reset_release_idle: got busy/winc/gid=%b want 0000", {busy, winc, grant_id});
        end
        cyc();
        tests++;
        if ({winc, req_ready, grant_id, wdata} !== {1'b1, 4'b0001, 2'd0, 8'hA0}) begin
            fails++;
            $display("FAIL reset_first_grant: got %h want %h", {winc, req_ready, grant_id, wdata}, {1'b1, 4'b0001, 2'd0, 8'hA0});
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  g;
        logic [14:0] e;
        do_reset();
        req_valid = 4'hF;
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL rr_initial_idle: got busy=%b want 0", busy);
        end
        cyc();
        for (int s = 0; s < 5; s++) begin
            g = 2'(s % 4);
            e = {1'b1, 4'b0001 << g, g, exp_data[g]};
            for (int w = 0; w < 4; w++) begin
                #1;
                tests++;
                if ({winc, req_ready, grant_id, wdata} !== e) begin
                    fails++;
                    $display("FAIL rr_grant%0d_word%0d: got %h want %h", s, w, {winc, req_ready, grant_id, wdata}, e);
                end
                cyc();
            end
            #1;
            tests++;
            if ({winc, busy, req_ready} !== 6'b0) begin
                fails++;
                $display("FAIL rr_bubble%0d: got winc/busy/ready=%b want 000000", s, {winc, busy, req_ready});
            end
            cyc();
        end
    endtask

    task automatic test_early_last();
        int n1 = 0;
        do_reset();
        req_valid = 4'b0110;
        cyc();
        for (int w = 0; w < 2; w++) begin
            req_last = (w == 1) ? 4'b0010 : 4'b0000;
            #1;
            tests++;
            if ({winc, req_ready, grant_id} !== {1'b1, 4'b0010, 2'd1}) begin
                fails++;
                $display("FAIL early_word%0d: got %b want 1001001", w, {winc, req_ready, grant_id});
            end
            if (winc && req_ready[1]) n1++;
            cyc();
        end
        req_valid = 4'b0100;
        req_last = '0;
        #1;
        tests++;
        if ({winc, busy} !== 2'b00) begin
            fails++;
            $display("FAIL early_bubble: got winc/busy=%b want 00", {winc, busy});
        end
        if (winc && req_ready[1]) n1++;
        cyc();
        tests++;
        if (n1 !== 2) begin
            fails++;
            $display("FAIL early_count: got %0d writes want 2", n1);
        end
        tests++;
        if ({winc, req_ready, grant_id, wdata} !== {1'b1, 4'b0100, 2'd2, 8'hC2}) begin
            fails++;
            $display("FAIL early_next_grant: got %h want %h", {winc, req_ready, grant_id, wdata}, {1'b1, 4'b0100, 2'd2, 8'hC2});
        end
    endtask

    task automatic test_full_stall();
        int n0 = 0;
        do_reset();
        req_valid = 4'b0001;
        cyc();
        for (int c = 0; c < 7; c++) begin
            wfull = (c >= 2 && c < 5);
            #1;
            tests++;
            if ({winc, req_ready, busy, grant_id} !== (wfull ? {1'b0, 4'b0000, 1'b1, 2'd0} : {1'b1, 4'b0001, 1'b1, 2'd0})) begin
                fails++;
                $display("FAIL stall_cycle%0d wfull=%b: got winc/ready/busy/gid=%b", c, wfull, {winc, req_ready, busy, grant_id});
            end
            if (winc) n0++;
            cyc();
        end
        wfull = 1'b0;
        #1;
        tests++;
        if ({winc, busy} !== 2'b00) begin
            fails++;
            $display("FAIL stall_end_idle: got winc/busy=%b want 00", {winc, busy});
        end
        tests++;
        if (n0 !== 4) begin
            fails++;
            $display("FAIL stall_count: got %0d writes want 4", n0);
        end
    endtask

    task automatic test_abandon();
        do_reset();
        req_valid = 4'b1100;
        cyc();
        #1;
        tests++;
        if ({winc, req_ready, grant_id} !== {1'b1, 4'b0100, 2'd2}) begin
            fails++;
            $display("FAIL abandon_word: got %b want 1010010", {winc, req_ready, grant_id});
        end
        cyc();
        req_valid = 4'b1001;
        #1;
        tests++;
        if ({winc, req_ready, busy} !== 6'b000001) begin
            fails++;
            $display("FAIL abandon_drop: got winc/ready/busy=%b want 000001", {winc, req_ready, busy});
        end
        cyc();
        #1;
        tests++;
        if ({winc, busy} !== 2'b00) begin
            fails++;
            $display("FAIL abandon_idle: got winc/busy=%b want 00", {winc, busy});
        end
        cyc();
        tests++;
        if ({winc, req_ready, grant_id, wdata} !== {1'b1, 4'b1000, 2'd3, 8'hD3}) begin
            fails++;
            $display("FAIL abandon_next_grant: got %h want %h", {winc, req_ready, grant_id, wdata}, {1'b1, 4'b1000, 2'd3, 8'hD3});
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid = 4'b1000;
        cyc();
        #1;
        tests++;
        if ({winc, req_ready, grant_id} !== {1'b1, 4'b1000, 2'd3}) begin
            fails++;
            $display("FAIL midrst_word1: got %b want 1100011", {winc, req_ready, grant_id});
        end
        cyc();
        wrst = 1'b1;
        #1;
        tests++;
        if ({winc, grant_id} !== {1'b1, 2'd3}) begin
            fails++;
            $display("FAIL midrst_word2: got winc/gid=%b want 111", {winc, grant_id});
        end
        cyc();
        req_valid = 4'b1001;
        #1;
        tests++;
        if ({winc, busy, req_ready} !== 6'b0) begin
            fails++;
            $display("FAIL midrst_in_reset: got winc/busy/ready=%b want 000000", {winc, busy, req_ready});
        end
        cyc();
        wrst = 1'b0;
        #1;
        tests++;
        if ({winc, busy, grant_id} !== 4'b0) begin
            fails++;
            $display("FAIL midrst_release: got winc/busy/gid=%b want 0000", {winc, busy, grant_id});
        end
        cyc();
        tests++;
        if ({winc, req_ready, grant_id} !== {1'b1, 4'b0001, 2'd0}) begin
            fails++;
            $display("FAIL midrst_first_grant: got %b want 1000100", {winc, req_ready, grant_id});
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_early_last();
        test_full_stall();
        test_abandon();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
